// File: rtl/qvga_frame_scheduler.sv
// qvga_frame_scheduler: double-buffer scheduler between the camera pixel
// stream and two frame banks. Camera pixels become bank write addresses.
// Bank swaps happen only at display frame boundaries. Camera frames that
// arrive while no bank is free are dropped and counted.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for cam_vsync, writes suppressed
// CAPTURE | writing pixels into wbank, pcnt = next write address
// DONE    | full frame held in wbank, waiting for disp_vsync to swap

module qvga_frame_scheduler #(
   parameter int H_RES = 320,
   parameter int V_RES = 240,
   parameter int DW    = 12,
   parameter int AW    = 17
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cam_vsync,
   input  logic          cam_we,
   input  logic [DW-1:0] cam_data,
   input  logic          disp_vsync,
   output logic          we,
   output logic [AW-1:0] wAddr,
   output logic [DW-1:0] wData,
   output logic          wbank,
   output logic          rbank,
   output logic          frame_valid,
   output logic [7:0]    frame_drops,
   output logic [7:0]    short_frames,
   output logic          busy
);

   localparam int            N    = H_RES * V_RES;
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   pcnt_q, pcnt_d;
   logic            we_q, we_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            wbank_q, wbank_d;
   logic            rbank_q, rbank_d;
   logic            fvalid_q, fvalid_d;
   logic [7:0]      drops_q, drops_d;
   logic [7:0]      shorts_q, shorts_d;
   logic            busy_q, busy_d;

   // Next-state, write-port and bank-swap decisions.
   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wbank_d  = wbank_q;
      rbank_d  = rbank_q;
      fvalid_d = fvalid_q;
      drops_d  = drops_q;
      shorts_d = shorts_q;

      unique case (state_q)
         IDLE: begin
            if (cam_vsync) begin
               state_d = CAPTURE;
               pcnt_d  = '0;
            end
         end
         CAPTURE: begin
            // A new camera frame restarts the same bank; the colliding pixel is lost.
            if (cam_vsync) begin
               pcnt_d = '0;
               if (shorts_q != 8'hFF) shorts_d = shorts_q + 8'd1;
            end else if (cam_we) begin
               we_d    = 1'b1;
               waddr_d = pcnt_q;
               wdata_d = cam_data;
               if (pcnt_q == LAST) begin
                  state_d = DONE;
                  pcnt_d  = '0;
               end else begin
                  pcnt_d = pcnt_q + AW'(1);
               end
            end
         end
         DONE: begin
            if (disp_vsync) begin
               rbank_d  = wbank_q;
               wbank_d  = ~wbank_q;
               fvalid_d = 1'b1;
               pcnt_d   = '0;
               state_d  = cam_vsync ? CAPTURE : IDLE;
            end else if (cam_vsync) begin
               if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CAPTURE);
   end

   // All state and registered outputs; reset returns them at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         pcnt_q   <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wbank_q  <= 1'b0;
         rbank_q  <= 1'b1;
         fvalid_q <= 1'b0;
         drops_q  <= 8'd0;
         shorts_q <= 8'd0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         wbank_q  <= wbank_d;
         rbank_q  <= rbank_d;
         fvalid_q <= fvalid_d;
         drops_q  <= drops_d;
         shorts_q <= shorts_d;
         busy_q   <= busy_d;
      end
   end

   assign we           = we_q;
   assign wAddr        = waddr_q;
   assign wData        = wdata_q;
   assign wbank        = wbank_q;
   assign rbank        = rbank_q;
   assign frame_valid  = fvalid_q;
   assign frame_drops  = drops_q;
   assign short_frames = shorts_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_qvga_frame_scheduler.sv
// Bench for qvga_frame_scheduler, run at a reduced 16x10 resolution so that
// several whole frames fit in a short simulation.

module tb_qvga_frame_scheduler;

   localparam int H_RES = 16;
   localparam int V_RES = 10;
   localparam int DW    = 12;
   localparam int AW    = 8;
   localparam int N     = H_RES * V_RES;
   localparam int VW    = 1 + AW + DW + 1 + 1 + 1 + 8 + 8 + 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cam_vsync, cam_we, disp_vsync;
   logic [DW-1:0] cam_data;
   logic          we, wbank, rbank, frame_valid, busy;
   logic [AW-1:0] wAddr;
   logic [DW-1:0] wData;
   logic [7:0]    frame_drops, short_frames;

   int vectors = 0;
   int miscompares = 0;

   qvga_frame_scheduler #(.H_RES(H_RES), .V_RES(V_RES), .DW(DW), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_we(cam_we),
      .cam_data(cam_data), .disp_vsync(disp_vsync), .we(we), .wAddr(wAddr),
      .wData(wData), .wbank(wbank), .rbank(rbank), .frame_valid(frame_valid),
      .frame_drops(frame_drops), .short_frames(short_frames), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: a frame is either being collected (m_capturing),
   // complete and awaiting display (m_ready), or neither.
   bit            m_capturing, m_ready;
   int            m_count;
   bit            m_we, m_wbank, m_rbank, m_valid;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   int            m_drops, m_shorts;

   task automatic model_reset();
      m_capturing = 0; m_ready = 0; m_count = 0;
      m_we = 0; m_waddr = '0; m_wdata = '0;
      m_wbank = 0; m_rbank = 1; m_valid = 0;
      m_drops = 0; m_shorts = 0;
   endtask

   task automatic model_clock(input bit v, input bit pw, input logic [DW-1:0] d, input bit dv);
      m_we = 0;
      if (m_ready) begin
         if (dv) begin
            m_rbank = m_wbank;
            m_wbank = !m_wbank;
            m_valid = 1;
            m_ready = 0;
            if (v) begin
               m_capturing = 1;
               m_count = 0;
            end
         end else if (v) begin
            m_drops = (m_drops < 255) ? m_drops + 1 : 255;
         end
      end else if (m_capturing) begin
         if (v) begin
            m_shorts = (m_shorts < 255) ? m_shorts + 1 : 255;
            m_count = 0;
         end else if (pw) begin
            m_we = 1;
            m_waddr = AW'(m_count);
            m_wdata = d;
            m_count++;
            if (m_count == N) begin
               m_capturing = 0;
               m_ready = 1;
            end
         end
      end else if (v) begin
         m_capturing = 1;
         m_count = 0;
      end
   endtask

   task automatic check(input string tag);
      logic [VW-1:0] obs, exp;
      obs = {we, wAddr, wData, wbank, rbank, frame_valid, frame_drops, short_frames, busy};
      exp = {m_we, m_waddr, m_wdata, m_wbank, m_rbank, m_valid,
             8'(m_drops), 8'(m_shorts), m_capturing};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s t=%0t obs=%h exp=%h (we,wAddr,wData,wbank,rbank,fv,drops,shorts,busy)",
                tag, $time, obs, exp);
      end
   endtask

   task automatic step(input string tag, input bit v, input bit pw, input bit dv);
      @(negedge clk);
      cam_vsync = v; cam_we = pw; disp_vsync = dv;
      cam_data = DW'($urandom);
      @(posedge clk);
      model_clock(v, pw, cam_data, dv);
      #1 check(tag);
   endtask

   task automatic pixels(input string tag, input int n);
      int k = 0;
      int guard = 0;
      while (k < n && guard < 8 * n + 8) begin
         bit pw;
         pw = ($urandom_range(3) != 0);
         step(tag, 0, pw, 0);
         if (pw) k++;
         guard++;
      end
   endtask

   task automatic finish_frame(input string tag);
      int guard = 0;
      while (m_capturing && guard < 8 * N) begin
         step(tag, 0, ($urandom_range(3) != 0), 0);
         guard++;
      end
      vectors++;
      assert (!m_capturing) else begin
         miscompares++;
         $error("FAIL %s_bound obs=capturing exp=done", tag);
      end
   endtask

   initial begin
      reset_n = 1'b0; cam_vsync = 0; cam_we = 0; disp_vsync = 0; cam_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check("reset");
      @(negedge clk) reset_n = 1'b1;

      // Pixels and display pulses before any camera frame are ignored.
      for (int i = 0; i < 5; i++) step("idle_pix", 0, 1, (i == 2));

      // First full frame, with a display pulse in the middle that must do nothing.
      step("vs1", 1, 0, 0);
      pixels("cap1", 50);
      step("disp_in_cap", 0, 1, 1);
      finish_frame("cap1_end");
      for (int i = 0; i < 3; i++) step("done_pix", 0, 1, 0);

      // Three dropped frames, then the swap.
      for (int i = 0; i < 3; i++) begin
         step("drop", 1, 0, 0);
         step("drop_gap", 0, 1, 0);
      end
      step("swap1", 0, 0, 1);
      step("post_swap", 0, 1, 0);

      // Short frame: restart after 100 pixels.
      step("vs2", 1, 0, 0);
      pixels("cap2", 100);
      step("short", 1, 1, 0);
      step("short_px0", 0, 1, 0);
      finish_frame("cap2_end");

      // Swap and new capture in the same cycle.
      step("swap_and_vs", 1, 0, 1);
      step("cap3_px0", 0, 1, 0);
      finish_frame("cap3_end");

      // Drop counter saturation.
      for (int i = 0; i < 300; i++) step("drop_sat", 1, 0, 0);
      step("swap_sat", 0, 0, 1);

      // Asynchronous reset in the middle of a capture.
      step("vs4", 1, 0, 0);
      pixels("cap4", 30);
      @(negedge clk);
      cam_we = 1;
      #2 reset_n = 1'b0;
      model_reset();
      #1 check("async_rst");
      @(negedge clk) reset_n = 1'b1;
      for (int i = 0; i < 6; i++) step("rst_ignored", 0, 1, 0);
      step("vs5", 1, 0, 0);
      pixels("cap5", 20);

      // Random tail.
      for (int i = 0; i < 1500; i++)
         step("rand", ($urandom_range(199) == 0), ($urandom_range(3) != 0),
              ($urandom_range(29) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
